// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the Wishbone address decoder:
//               decoder FSM state type, CTI/BTE cycle-type encodings and the
//               byte-select width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // Decoder FSM states, explicitly encoded in 2 bits
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_UNMAPPED = 2'd2
    } wb_dec_state_t;

    // Cycle type identifiers (registered feedback)
    localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] c_CTI_CONST   = 3'b001;
    localparam logic [2:0] c_CTI_INCR    = 3'b010;
    localparam logic [2:0] c_CTI_EOB     = 3'b111;

    // Burst type extensions
    localparam logic [1:0] c_BTE_LINEAR  = 2'b00;
    localparam logic [1:0] c_BTE_WRAP4   = 2'b01;
    localparam logic [1:0] c_BTE_WRAP8   = 2'b10;
    localparam logic [1:0] c_BTE_WRAP16  = 2'b11;

    // One byte-select line per data byte
    function automatic int wb_sel_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : wb_addr_decode
// Description : Combinational base/mask address matcher. Produces a one-hot
//               select of the lowest-index matching slave and a hit flag.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_addr_decode #(
    parameter int                                SLAVES     = 2,
    parameter int                                ADDR_WIDTH = 32,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_BASE     = '0,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_MASK     = '0
) (
    input  logic [ADDR_WIDTH-1:0] i_adr,
    output logic [SLAVES-1:0]     o_match,
    output logic                  o_hit
);

    logic [SLAVES-1:0] w_raw;

    generate
        for (genvar gi = 0; gi < SLAVES; gi++) begin : g_cmp
            assign w_raw[gi] = ((i_adr & S_MASK[gi]) == (S_BASE[gi] & S_MASK[gi]));
        end
    endgenerate

    // Priority pick: scan high to low so the lowest matching index is written last
    always_comb begin
        o_match = '0;
        for (int i = SLAVES - 1; i >= 0; i--) begin
            if (w_raw[i]) begin
                o_match    = '0;
                o_match[i] = 1'b1;
            end
        end
    end

    assign o_hit = |w_raw;

endmodule
`default_nettype wire

// File: rtl/wb_decode.sv
`default_nettype none
// ============================================================================
// Module      : wb_decode
// Description : Wishbone single-master to multi-slave decoder/splitter.
//               Decodes the first strobe of a bus cycle, locks the selected
//               slave until m_cyc_i falls, and terminates unmapped accesses
//               and unresponsive slaves with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_decode
    import wb_pkg::*;
#(
    parameter int                                SLAVES     = 2,
    parameter int                                DATA_WIDTH = 32,
    parameter int                                ADDR_WIDTH = 32,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_BASE     = '0,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_MASK     = '0,
    parameter int                                TIMEOUT    = 255,
    localparam int                               SEL_WIDTH  = wb_sel_width(DATA_WIDTH)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    // master side
    input  logic [ADDR_WIDTH-1:0]               m_adr_i,
    input  logic [DATA_WIDTH-1:0]               m_dat_i,
    input  logic                                m_cyc_i,
    input  logic                                m_stb_i,
    input  logic [SEL_WIDTH-1:0]                m_sel_i,
    input  logic                                m_we_i,
    input  logic [2:0]                          m_cti_i,
    input  logic [1:0]                          m_bte_i,
    output logic [DATA_WIDTH-1:0]               m_dat_o,
    output logic                                m_ack_o,
    output logic                                m_err_o,
    output logic                                m_rty_o,
    // slave side
    output logic [ADDR_WIDTH-1:0]               s_adr_o,
    output logic [DATA_WIDTH-1:0]               s_dat_o,
    output logic [SEL_WIDTH-1:0]                s_sel_o,
    output logic                                s_we_o,
    output logic [2:0]                          s_cti_o,
    output logic [1:0]                          s_bte_o,
    output logic [SLAVES-1:0]                   s_cyc_o,
    output logic [SLAVES-1:0]                   s_stb_o,
    input  logic [SLAVES-1:0][DATA_WIDTH-1:0]   s_dat_i,
    input  logic [SLAVES-1:0]                   s_ack_i,
    input  logic [SLAVES-1:0]                   s_err_i,
    input  logic [SLAVES-1:0]                   s_rty_i
);

    // Counter is sized for TIMEOUT but kept at least one bit wide so a
    // disabled watchdog still elaborates cleanly.
    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic             c_WD_EN    = (TIMEOUT > 0);

    wb_dec_state_t     state_q, state_d;
    logic [SLAVES-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic                  w_req;
    logic [SLAVES-1:0]     w_match;
    logic                  w_hit;
    logic [SLAVES-1:0]     w_route;
    logic                  w_term;
    logic                  w_wd_err;
    logic [DATA_WIDTH-1:0] w_dat;

    assign w_req = m_cyc_i & m_stb_i;

    wb_addr_decode #(
        .SLAVES     (SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .S_BASE     (S_BASE),
        .S_MASK     (S_MASK)
    ) u_addr_decode (
        .i_adr   (m_adr_i),
        .o_match (w_match),
        .o_hit   (w_hit)
    );

    // Request fields are broadcast unconditionally; only cyc/stb are steered
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;
    assign s_cti_o = m_cti_i;
    assign s_bte_o = m_bte_i;

    // Response routing: live decode on the first strobe, latched select after
    always_comb begin
        w_route = '0;
        if (state_q == ST_IDLE) begin
            w_route = w_req ? w_match : '0;
        end else if (state_q == ST_ACTIVE) begin
            w_route = sel_q;
        end
    end

    // Per-slave cyc/stb, forced low in any reset cycle
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE: begin
                    s_cyc_o = w_route;
                    s_stb_o = w_route;
                end
                ST_ACTIVE: begin
                    s_cyc_o = sel_q & {SLAVES{m_cyc_i}};
                    s_stb_o = sel_q & {SLAVES{m_stb_i}};
                end
                default: begin
                    s_cyc_o = '0;
                    s_stb_o = '0;
                end
            endcase
        end
    end

    // Read data mux: select is one-hot or zero, so an AND-OR tree suffices
    always_comb begin
        w_dat = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (w_route[i]) begin
                w_dat = w_dat | s_dat_i[i];
            end
        end
    end

    // A slave termination in the same cycle as expiry takes precedence
    assign w_term   = |(w_route & (s_ack_i | s_err_i | s_rty_i));
    assign w_wd_err = c_WD_EN && (state_q == ST_ACTIVE) && w_req && !w_term
                      && (cnt_q == c_CNT_LAST);

    assign m_dat_o = rst_i ? '0 : w_dat;
    assign m_ack_o = !rst_i && |(w_route & s_ack_i);
    assign m_rty_o = !rst_i && |(w_route & s_rty_i);
    assign m_err_o = !rst_i && ((|(w_route & s_err_i)) || w_wd_err
                                || ((state_q == ST_UNMAPPED) && err_q));

    // Next-state, slave lock, watchdog count and unmapped error pulse
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (w_req) begin
                    sel_d = w_match;
                    if (w_hit) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_UNMAPPED;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end else if (w_term || w_wd_err) begin
                    cnt_d = '0;
                end else if (c_WD_EN && m_stb_i && (cnt_q != c_CNT_MAX)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UNMAPPED: begin
                sel_d = '0;
                cnt_d = '0;
                if (!m_cyc_i) begin
                    state_d = ST_IDLE;
                end else begin
                    // High for one cycle, then low for at least one
                    err_d = m_stb_i & ~err_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_decode.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_wb_decode
// Description : Directed scoreboard bench for wb_decode. Expected outputs are
//               queued when each cycle's stimulus is driven and compared on
//               the following falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_decode;
    import wb_pkg::*;

    localparam int SLAVES = 2;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int TO     = 4;

    localparam logic [SLAVES-1:0][AW-1:0] c_BASE    = {32'h8000_0000, 32'h0000_0000};
    localparam logic [SLAVES-1:0][AW-1:0] c_MASK    = {32'hF000_0000, 32'hF000_0000};
    // Slave 0 matches everything, slave 1 matches 0x8xxx_xxxx: overlap case
    localparam logic [SLAVES-1:0][AW-1:0] c_OV_MASK = {32'hF000_0000, 32'h0000_0000};

    localparam int F_SCYC    = 0;
    localparam int F_SSTB    = 1;
    localparam int F_ACK     = 2;
    localparam int F_ERR     = 3;
    localparam int F_RTY     = 4;
    localparam int F_DAT     = 5;
    localparam int F_SADR    = 6;
    localparam int F_OV_SCYC = 7;
    localparam int F_OV_DAT  = 8;
    localparam int F_OV_ACK  = 9;

    logic                        clk_i = 1'b0;
    logic                        rst_i;
    logic [AW-1:0]               m_adr_i;
    logic [DW-1:0]               m_dat_i;
    logic                        m_cyc_i, m_stb_i, m_we_i;
    logic [DW/8-1:0]             m_sel_i;
    logic [2:0]                  m_cti_i;
    logic [1:0]                  m_bte_i;
    logic [SLAVES-1:0][DW-1:0]   s_dat_i;
    logic [SLAVES-1:0]           s_ack_i, s_err_i, s_rty_i;

    logic [DW-1:0]     m_dat_o, ov_m_dat_o;
    logic              m_ack_o, m_err_o, m_rty_o;
    logic              ov_m_ack_o, ov_m_err_o, ov_m_rty_o;
    logic [AW-1:0]     s_adr_o, ov_s_adr_o;
    logic [DW-1:0]     s_dat_o, ov_s_dat_o;
    logic [DW/8-1:0]   s_sel_o, ov_s_sel_o;
    logic              s_we_o, ov_s_we_o;
    logic [2:0]        s_cti_o, ov_s_cti_o;
    logic [1:0]        s_bte_o, ov_s_bte_o;
    logic [SLAVES-1:0] s_cyc_o, s_stb_o, ov_s_cyc_o, ov_s_stb_o;

    always #5 clk_i = ~clk_i;

    wb_decode #(
        .SLAVES(SLAVES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .S_BASE(c_BASE), .S_MASK(c_MASK), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    wb_decode #(
        .SLAVES(SLAVES), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .S_BASE(c_BASE), .S_MASK(c_OV_MASK), .TIMEOUT(TO)
    ) dut_ov (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_sel_i(m_sel_i), .m_we_i(m_we_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(ov_m_dat_o), .m_ack_o(ov_m_ack_o), .m_err_o(ov_m_err_o), .m_rty_o(ov_m_rty_o),
        .s_adr_o(ov_s_adr_o), .s_dat_o(ov_s_dat_o), .s_sel_o(ov_s_sel_o), .s_we_o(ov_s_we_o),
        .s_cti_o(ov_s_cti_o), .s_bte_o(ov_s_bte_o), .s_cyc_o(ov_s_cyc_o), .s_stb_o(ov_s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
    );

    typedef struct {
        string       tag;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            F_SCYC:    return {30'd0, s_cyc_o};
            F_SSTB:    return {30'd0, s_stb_o};
            F_ACK:     return {31'd0, m_ack_o};
            F_ERR:     return {31'd0, m_err_o};
            F_RTY:     return {31'd0, m_rty_o};
            F_DAT:     return m_dat_o;
            F_SADR:    return s_adr_o;
            F_OV_SCYC: return {30'd0, ov_s_cyc_o};
            F_OV_DAT:  return ov_m_dat_o;
            F_OV_ACK:  return {31'd0, ov_m_ack_o};
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int fld, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.exp = val;
        sb_q.push_back(e);
    endtask

    // Compare everything queued for this cycle, then advance to the next one
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk_i);
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.fld);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic master(input logic cyc, input logic stb, input logic [AW-1:0] adr,
                          input logic we, input logic [2:0] cti);
        m_cyc_i = cyc;
        m_stb_i = stb;
        m_adr_i = adr;
        m_we_i  = we;
        m_cti_i = cti;
    endtask

    task automatic slave(input logic [1:0] ack, input logic [1:0] err, input logic [1:0] rty);
        s_ack_i = ack;
        s_err_i = err;
        s_rty_i = rty;
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst_i   = 1'b1;
        m_dat_i = 32'h1234_5678;
        m_sel_i = 4'hF;
        m_bte_i = c_BTE_LINEAR;
        s_dat_i = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        @(posedge clk_i);
        #1;

        // Reset: outputs forced even with an active request and busy slaves
        master(1'b1, 1'b1, 32'h8000_0010, 1'b1, c_CTI_CLASSIC);
        slave(2'b11, 2'b11, 2'b11);
        expect_val("rst_scyc", F_SCYC, 32'h0);
        expect_val("rst_sstb", F_SSTB, 32'h0);
        expect_val("rst_ack", F_ACK, 32'h0);
        expect_val("rst_err", F_ERR, 32'h0);
        expect_val("rst_rty", F_RTY, 32'h0);
        expect_val("rst_dat", F_DAT, 32'h0);
        expect_val("rst_sadr", F_SADR, 32'h8000_0010);
        expect_val("rst_ov_scyc", F_OV_SCYC, 32'h0);
        tick();

        rst_i = 1'b0;
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        expect_val("idle_scyc", F_SCYC, 32'h0);
        expect_val("idle_ack", F_ACK, 32'h0);
        tick();

        // cyc without stb drives nothing
        master(1'b1, 1'b0, 32'h8000_0010, 1'b1, c_CTI_CLASSIC);
        expect_val("nostb_scyc", F_SCYC, 32'h0);
        expect_val("nostb_sstb", F_SSTB, 32'h0);
        tick();

        // Mapped write, slave 1 acks in cycle 0
        master(1'b1, 1'b1, 32'h8000_0010, 1'b1, c_CTI_CLASSIC);
        slave(2'b10, 2'b00, 2'b00);
        expect_val("map_sstb", F_SSTB, 32'h2);
        expect_val("map_scyc", F_SCYC, 32'h2);
        expect_val("map_ack", F_ACK, 32'h1);
        expect_val("map_err", F_ERR, 32'h0);
        tick();
        master(1'b0, 1'b0, 32'h8000_0010, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        expect_val("map_drop_scyc", F_SCYC, 32'h0);
        expect_val("map_drop_ack", F_ACK, 32'h0);
        tick();

        // Retry passes through from the selected slave
        master(1'b1, 1'b1, 32'h8000_0020, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b10);
        expect_val("rty_rty", F_RTY, 32'h1);
        expect_val("rty_ack", F_ACK, 32'h0);
        tick();
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        tick();

        // Incrementing burst crossing out of slave 0's window stays on slave 0
        master(1'b1, 1'b1, 32'h0FFF_FFF8, 1'b1, c_CTI_INCR);
        slave(2'b01, 2'b00, 2'b00);
        expect_val("burst0_scyc", F_SCYC, 32'h1);
        expect_val("burst0_ack", F_ACK, 32'h1);
        tick();
        m_adr_i = 32'h0FFF_FFFC;
        expect_val("burst1_scyc", F_SCYC, 32'h1);
        tick();
        m_adr_i = 32'h1000_0000;
        expect_val("burst2_scyc", F_SCYC, 32'h1);
        expect_val("burst2_sstb", F_SSTB, 32'h1);
        expect_val("burst2_ack", F_ACK, 32'h1);
        expect_val("burst2_err", F_ERR, 32'h0);
        tick();
        m_adr_i = 32'h1000_0004;
        m_cti_i = c_CTI_EOB;
        expect_val("burst3_scyc", F_SCYC, 32'h1);
        tick();
        master(1'b0, 1'b0, 32'h1000_0008, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        expect_val("burst_end_scyc", F_SCYC, 32'h0);
        tick();

        // Unmapped access with strobe held: err 0,1,0,1 and no slave drive
        master(1'b1, 1'b1, 32'h4000_0000, 1'b0, c_CTI_CLASSIC);
        slave(2'b11, 2'b00, 2'b11);
        expect_val("um0_scyc", F_SCYC, 32'h0);
        expect_val("um0_err", F_ERR, 32'h0);
        expect_val("um0_ack", F_ACK, 32'h0);
        tick();
        expect_val("um1_err", F_ERR, 32'h1);
        expect_val("um1_ack", F_ACK, 32'h0);
        expect_val("um1_rty", F_RTY, 32'h0);
        expect_val("um1_scyc", F_SCYC, 32'h0);
        tick();
        expect_val("um2_err", F_ERR, 32'h0);
        tick();
        expect_val("um3_err", F_ERR, 32'h1);
        tick();
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        expect_val("um4_err", F_ERR, 32'h0);
        tick();

        // Watchdog: silent slave, error at cycle TIMEOUT only
        master(1'b1, 1'b1, 32'h8000_0000, 1'b0, c_CTI_CLASSIC);
        expect_val("wd0_err", F_ERR, 32'h0);
        expect_val("wd0_sstb", F_SSTB, 32'h2);
        tick();
        expect_val("wd1_err", F_ERR, 32'h0);
        tick();
        expect_val("wd2_err", F_ERR, 32'h0);
        tick();
        expect_val("wd3_err", F_ERR, 32'h0);
        tick();
        expect_val("wd4_err", F_ERR, 32'h1);
        expect_val("wd4_ack", F_ACK, 32'h0);
        tick();
        expect_val("wd5_err", F_ERR, 32'h0);
        expect_val("wd5_sstb", F_SSTB, 32'h2);
        tick();
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        expect_val("wd_end_scyc", F_SCYC, 32'h0);
        tick();

        // Ack at cycle 3 terminates normally and restarts the count
        master(1'b1, 1'b1, 32'h8000_0000, 1'b0, c_CTI_CLASSIC);
        tick();
        tick();
        expect_val("ack3_c2_err", F_ERR, 32'h0);
        tick();
        slave(2'b10, 2'b00, 2'b00);
        expect_val("ack3_ack", F_ACK, 32'h1);
        expect_val("ack3_err", F_ERR, 32'h0);
        tick();
        slave(2'b00, 2'b00, 2'b00);
        expect_val("ack3_c4_err", F_ERR, 32'h0);
        tick();
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        tick();

        // Ack coincident with expiry: ack wins, no error
        master(1'b1, 1'b1, 32'h8000_0000, 1'b0, c_CTI_CLASSIC);
        tick();
        tick();
        tick();
        tick();
        slave(2'b10, 2'b00, 2'b00);
        expect_val("ack4_ack", F_ACK, 32'h1);
        expect_val("ack4_err", F_ERR, 32'h0);
        tick();
        slave(2'b00, 2'b00, 2'b00);
        expect_val("ack4_c5_err", F_ERR, 32'h0);
        tick();
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        tick();

        // Overlapping windows: lowest index wins on the overlap instance
        master(1'b1, 1'b1, 32'h8000_0000, 1'b0, c_CTI_CLASSIC);
        slave(2'b11, 2'b00, 2'b00);
        expect_val("ov_scyc", F_OV_SCYC, 32'h1);
        expect_val("ov_dat", F_OV_DAT, 32'hDEAD_BEEF);
        expect_val("ov_ack", F_OV_ACK, 32'h1);
        expect_val("ov_main_scyc", F_SCYC, 32'h2);
        expect_val("ov_main_dat", F_DAT, 32'hCAFE_F00D);
        tick();
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        tick();

        // Reset during ACTIVE drops cyc at once; next strobe is re-decoded
        master(1'b1, 1'b1, 32'h8000_0000, 1'b0, c_CTI_CLASSIC);
        expect_val("rm0_scyc", F_SCYC, 32'h2);
        tick();
        expect_val("rm1_scyc", F_SCYC, 32'h2);
        tick();
        rst_i = 1'b1;
        expect_val("rm2_scyc", F_SCYC, 32'h0);
        expect_val("rm2_sstb", F_SSTB, 32'h0);
        expect_val("rm2_err", F_ERR, 32'h0);
        tick();
        rst_i = 1'b0;
        m_adr_i = 32'h0000_0040;
        slave(2'b01, 2'b00, 2'b00);
        expect_val("rm3_scyc", F_SCYC, 32'h1);
        expect_val("rm3_ack", F_ACK, 32'h1);
        expect_val("rm3_dat", F_DAT, 32'hDEAD_BEEF);
        tick();
        master(1'b0, 1'b0, 32'h0, 1'b0, c_CTI_CLASSIC);
        slave(2'b00, 2'b00, 2'b00);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
